// File: rtl/wb_dec_n_pkg.sv
// Shared types and default memory map for the Wishbone address decoder.
// Slot order: 0 = ROM, 1 = RAM, 2 = PERIPH, 3 = SDRAM.
package wb_dec_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int DEF_SLAVES = 4;
  localparam int DEF_ADR_W  = 30;

  // Word-address windows; the mask keeps the bits above each region size.
  localparam logic [DEF_ADR_W-1:0] ROM_BASE    = 30'h0000_0000;
  localparam logic [DEF_ADR_W-1:0] ROM_MASK    = 30'h3FFF_FC00;
  localparam logic [DEF_ADR_W-1:0] RAM_BASE    = 30'h0000_0400;
  localparam logic [DEF_ADR_W-1:0] RAM_MASK    = 30'h3FFF_FC00;
  localparam logic [DEF_ADR_W-1:0] PERIPH_BASE = 30'h0000_0800;
  localparam logic [DEF_ADR_W-1:0] PERIPH_MASK = 30'h3FFF_F800;
  localparam logic [DEF_ADR_W-1:0] SDRAM_BASE  = 30'h0000_8000;
  localparam logic [DEF_ADR_W-1:0] SDRAM_MASK  = 30'h3FFF_8000;

  localparam logic [DEF_SLAVES*DEF_ADR_W-1:0] DEF_BASE =
    {SDRAM_BASE, PERIPH_BASE, RAM_BASE, ROM_BASE};
  localparam logic [DEF_SLAVES*DEF_ADR_W-1:0] DEF_MASK =
    {SDRAM_MASK, PERIPH_MASK, RAM_MASK, ROM_MASK};

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_dec_n_match.sv
// Combinational priority address matcher: one-hot select of the lowest
// matching slot, plus a hit flag.
module wb_dec_n_match #(
  parameter int                          SLAVES = 4,
  parameter int                          ADR_W  = 30,
  parameter logic [SLAVES*ADR_W-1:0]     BASE   = '0,
  parameter logic [SLAVES*ADR_W-1:0]     MASK   = '0
) (
  input  logic [ADR_W-1:0]  adr_i,
  output logic [SLAVES-1:0] sel_o,
  output logic              hit_o
);

  // Scan from the top so the lowest matching index overwrites the rest.
  always_comb begin
    sel_o = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (((adr_i ^ BASE[i*ADR_W +: ADR_W]) & MASK[i*ADR_W +: ADR_W]) == '0) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

  assign hit_o = |sel_o;

endmodule

// File: rtl/wb_dec_n.sv
// Wishbone classic decoder/router: one master to SLAVES slaves, with
// registered select and bus-error termination for unmapped or silent slaves.
module wb_dec_n
  import wb_dec_n_pkg::*;
#(
  parameter int                      SLAVES  = 4,
  parameter int                      ADR_W   = 30,
  parameter logic [SLAVES*ADR_W-1:0] BASE    = DEF_BASE,
  parameter logic [SLAVES*ADR_W-1:0] MASK    = DEF_MASK,
  parameter int                      TIMEOUT = 255,
  parameter logic [31:0]             ERR_DAT = 32'hFFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic [ADR_W-1:0]     adr_i,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [31:0]          dat_o,
  output logic [SLAVES-1:0]    slv_stb_o,
  input  logic [SLAVES-1:0]    slv_ack_i,
  input  logic [32*SLAVES-1:0] slv_dat_i
);

  localparam int               CNT_W   = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [SLAVES-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       dat_q, dat_d;

  logic [SLAVES-1:0] match_sel;
  logic              match_hit;
  logic [31:0]       sel_dat;

  wb_dec_n_match #(
    .SLAVES (SLAVES),
    .ADR_W  (ADR_W),
    .BASE   (BASE),
    .MASK   (MASK)
  ) u_match (
    .adr_i  (adr_i),
    .sel_o  (match_sel),
    .hit_o  (match_hit)
  );

  // sel_q is one-hot, so an AND-OR mux picks the selected slave's data.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (sel_q[i]) sel_dat = sel_dat | slv_dat_i[i*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (match_hit) begin
            sel_d   = match_sel;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            dat_d   = ERR_DAT;
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Ack takes priority over a timeout landing in the same cycle.
          if (|(slv_ack_i & sel_q)) begin
            dat_d   = sel_dat;
            state_d = ST_DONE;
          end else if (cnt_q == CNT_MAX) begin
            dat_d   = ERR_DAT;
            state_d = ST_ERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  assign ack_o     = (state_q == ST_DONE);
  assign err_o     = (state_q == ST_ERR);
  assign dat_o     = dat_q;
  assign slv_stb_o = (state_q == ST_BUSY && cyc_i) ? sel_q : '0;

endmodule

// File: tb/tb_wb_dec_n.sv
// Directed bench for wb_dec_n: default map with TIMEOUT=8, plus a second
// instance whose slot 0 matches everything to exercise priority.
module tb_wb_dec_n;
  import wb_dec_n_pkg::*;

  localparam logic [119:0] OV_MASK = DEF_MASK & ~120'h3FFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb;
  logic [29:0]  adr;
  logic [3:0]   slv_ack;
  logic [127:0] slv_dat;

  logic         ack, err, ov_ack, ov_err;
  logic [31:0]  dat, ov_dat;
  logic [3:0]   slv_stb, ov_stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_dec_n #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
    .ack_o(ack), .err_o(err), .dat_o(dat), .slv_stb_o(slv_stb),
    .slv_ack_i(slv_ack), .slv_dat_i(slv_dat)
  );

  wb_dec_n #(.TIMEOUT(8), .MASK(OV_MASK)) dut_ov (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
    .ack_o(ov_ack), .err_o(ov_err), .dat_o(ov_dat), .slv_stb_o(ov_stb),
    .slv_ack_i(slv_ack), .slv_dat_i(slv_dat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; slv_ack = '0;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; adr = '0; slv_ack = '0; slv_dat = '0;
    step(); step();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dat, 32'd0);
    chk("rst_stb", {28'd0, slv_stb}, 32'd0);
    rst_n = 1'b1;
    step();

    // Overlap: 0x8000 hits SDRAM on the default map, slot 0 on the overlap map.
    cyc = 1'b1; stb = 1'b1; adr = 30'h8000;
    slv_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    step();
    chk("ovl_stb_default", {28'd0, slv_stb}, 32'h8);
    chk("ovl_stb_lowest", {28'd0, ov_stb}, 32'h1);
    slv_ack = 4'b1001;
    step();
    chk("ovl_ack", {31'd0, ack}, 32'd1);
    chk("ovl_dat", dat, 32'h3333_3333);
    chk("ovl_dat_lowest", ov_dat, 32'h0000_0000);
    idle_bus();
    step();

    // Read slave 1, ack 3 cycles after strobe.
    cyc = 1'b1; stb = 1'b1; adr = 30'h400;
    slv_dat = {32'h0, 32'h0, 32'hCAFE_BABE, 32'h0};
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd1_stb_%0d", k), {28'd0, slv_stb}, 32'h2);
      chk($sformatf("rd1_noack_%0d", k), {30'd0, ack, err}, 32'd0);
      if (k == 2) slv_ack = 4'b0010;
      step();
    end
    chk("rd1_ack", {30'd0, ack, err}, 32'h2);
    chk("rd1_dat", dat, 32'hCAFE_BABE);
    chk("rd1_stb_off", {28'd0, slv_stb}, 32'h0);
    idle_bus();
    step();
    chk("rd1_ack_pulse", {31'd0, ack}, 32'd0);

    // Unmapped address.
    cyc = 1'b1; stb = 1'b1; adr = 30'h3FFF_0000;
    step();
    chk("unm_err", {30'd0, ack, err}, 32'h1);
    chk("unm_dat", dat, 32'hFFFF_FFFF);
    chk("unm_stb", {28'd0, slv_stb}, 32'h0);
    idle_bus();
    step();
    chk("unm_err_pulse", {31'd0, err}, 32'd0);

    // Timeout on slave 0, stray ack from slave 3 ignored.
    cyc = 1'b1; stb = 1'b1; adr = 30'h10;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_stb_%0d", k), {28'd0, slv_stb}, 32'h1);
      chk($sformatf("to_wait_%0d", k), {30'd0, ack, err}, 32'd0);
      slv_ack = (k == 3) ? 4'b1000 : 4'b0000;
      step();
    end
    chk("to_err", {30'd0, ack, err}, 32'h1);
    chk("to_dat", dat, 32'hFFFF_FFFF);
    chk("to_stb_off", {28'd0, slv_stb}, 32'h0);
    idle_bus();
    step();

    // Abort: cyc drops in BUSY, late ack ignored.
    cyc = 1'b1; stb = 1'b1; adr = 30'h800;
    slv_dat = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    step();
    chk("ab_stb", {28'd0, slv_stb}, 32'h4);
    cyc = 1'b0; stb = 1'b0;
    #1;
    chk("ab_stb_drop", {28'd0, slv_stb}, 32'h0);
    step();
    chk("ab_none", {30'd0, ack, err}, 32'd0);
    slv_ack = 4'b0100;
    step();
    chk("ab_late_ack", {30'd0, ack, err}, 32'd0);
    chk("ab_dat_hold", dat, 32'hFFFF_FFFF);
    idle_bus();
    step();

    // Back-to-back reads: slave 0 then slave 2 with stb held.
    cyc = 1'b1; stb = 1'b1; adr = 30'h5;
    slv_dat = {32'h0, 32'hB2B2_B2B2, 32'h0, 32'hA0A0_A0A0};
    step();
    chk("b2b_stb0", {28'd0, slv_stb}, 32'h1);
    slv_ack = 4'b0001;
    step();
    chk("b2b_ack0", {31'd0, ack}, 32'd1);
    chk("b2b_dat0", dat, 32'hA0A0_A0A0);
    slv_ack = 4'b0000; adr = 30'h805;
    step();
    chk("b2b_gap", {28'd0, slv_stb, 3'd0, ack}, 32'd0);
    step();
    chk("b2b_stb2", {28'd0, slv_stb}, 32'h4);
    slv_ack = 4'b0100;
    step();
    chk("b2b_ack2", {30'd0, ack, err}, 32'h2);
    chk("b2b_dat2", dat, 32'hB2B2_B2B2);
    idle_bus();
    step();

    // Asynchronous reset mid-BUSY, then a normal access.
    cyc = 1'b1; stb = 1'b1; adr = 30'h800;
    step();
    chk("rb_stb", {28'd0, slv_stb}, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rb_stb_clr", {28'd0, slv_stb}, 32'h0);
    chk("rb_ack_err", {30'd0, ack, err}, 32'd0);
    chk("rb_dat_clr", dat, 32'd0);
    idle_bus();
    step();
    rst_n = 1'b1;
    step();
    cyc = 1'b1; stb = 1'b1; adr = 30'h400;
    slv_dat = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
    step();
    chk("rb_next_stb", {28'd0, slv_stb}, 32'h2);
    slv_ack = 4'b0010;
    step();
    chk("rb_next_ack", {30'd0, ack, err}, 32'h2);
    chk("rb_next_dat", dat, 32'h1234_5678);
    idle_bus();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dec_n.md
Name: wb_dec_n

Overview:
Parametrised Wishbone classic address decoder/router: one bus master (the CPU-interface bridge) to SLAVES slave ports.
- Slave address windows are described by base/mask parameter vectors.
- Decode and slave select are registered.
- Unmapped accesses and slaves that never acknowledge are terminated with a bus-error pulse, so the CPU bus cannot hang.
- Replaces the fixed four-way decoder and the fixed peripheral fan-out in the SoC top.

Parameters:
SLAVES, 4, number of slave ports (1..16)
ADR_W, 30, word-address width
BASE, {16'h0000,16'h0400,16'h0800,16'h8000} (zero-extended per slot), packed SLAVES*ADR_W vector of region base word addresses; slot i = bits [i*ADR_W +: ADR_W]
MASK, matching packed SLAVES*ADR_W vector, region compare mask; 1 = bit compared
TIMEOUT, 255, cycles in BUSY before a forced error (>=2)
ERR_DAT, 32'hFFFF_FFFF, dat_o value on error termination

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-low
cyc_i  in  1  master cycle
stb_i  in  1  master strobe
adr_i  in  ADR_W  master word address
ack_o  out  1  transfer acknowledge, one-cycle pulse
err_o  out  1  transfer error, one-cycle pulse
dat_o  out  32  read data to master, registered
slv_stb_o  out  SLAVES  one-hot slave strobe
slv_ack_i  in  SLAVES  slave acknowledges
slv_dat_i  in  32*SLAVES  slave read data; slot i = bits [i*32 +: 32]

Behaviour:
- Reset (rst_i low, asynchronous):
  - outputs: ack_o=0, err_o=0, dat_o=0, slv_stb_o=0
  - internal: state=IDLE, sel=0, timeout counter=0
- Match rule: slot i matches when (adr_i & MASK_i) == (BASE_i & MASK_i). If several slots match, the lowest index wins.
- IDLE, on cyc_i & stb_i:
  - hit: latch one-hot sel, load counter=0, go to BUSY.
  - miss: go to ERR.
- BUSY:
  - slv_stb_o = sel, while cyc_i is high.
  - Counter increments every cycle.
  - If slv_ack_i & sel is nonzero: capture the selected slv_dat_i into dat_o, go to DONE.
  - Acks from unselected slaves are ignored.
  - Else if counter == TIMEOUT-1: go to ERR.
  - A simultaneous ack and timeout in the same cycle counts as an ack.
- DONE: ack_o=1 for exactly this cycle, slv_stb_o=0, then go to IDLE. Any stb_i seen in this cycle is ignored.
- ERR: err_o=1 for exactly this cycle, dat_o=ERR_DAT, slv_stb_o=0, then go to IDLE.
- Abort: cyc_i low in BUSY drops slv_stb_o combinationally. The block returns to IDLE next cycle with no ack_o/err_o. A late slave ack after abort is ignored.
- Latency:
  - Request seen in cycle N gives slv_stb_o high from N+1.
  - Slave ack in cycle M gives ack_o in M+1.
  - Unmapped access gives err_o in N+1.
- Exclusivity: ack_o and err_o are never high together. slv_stb_o is at most one-hot.
- Back-to-back transfers: the master holding stb_i after DONE/ERR starts a new decode in the next IDLE cycle. Minimum spacing is 3 cycles per transfer.
- dat_o holds its last value between transfers.
- Writes route identically; this block does not touch we/sel/dat_o of the master.

Decomposition:
- Package wb_dec_n_pkg:
  - state encoding (IDLE, BUSY, DONE, ERR)
  - default BASE/MASK map constants (ROM, RAM, PERIPH, SDRAM)
  - clog2 helper for counter width
- Sub-module wb_dec_n_match: combinational priority matcher; in adr, params BASE/MASK; out one-hot sel and hit.

Test Plan:
- Reset mid-BUSY: rst_i low while slave 2 strobed -> slv_stb_o=0, ack_o=0, err_o=0, dat_o=0 immediately; after release, the next access decodes normally.
- Read slave 1: adr_i=0x400, slave 1 acks 3 cycles after strobe with 0xCAFEBABE -> slv_stb_o=4'b0010 from N+1; ack_o one pulse at M+1 with dat_o=0xCAFEBABE; no err_o.
- Overlapping windows: slot 0 MASK=0 (match-all) and slot 3 matching adr 0x8000 -> slv_stb_o=4'b0001 (lowest index wins).
- Unmapped: all slots mismatch adr 0x3FFF_0000 -> err_o pulse at N+1, dat_o=0xFFFFFFFF, slv_stb_o stays 0.
- Timeout: TIMEOUT=8, slave 0 never acks -> slv_stb_o high 8 cycles, then err_o pulse; a stray ack on slave 3 during the wait is ignored.
- Abort and back-to-back: cyc_i drops in BUSY -> no ack_o/err_o, and a late slave ack is ignored; two consecutive reads to slaves 0 then 2 -> two ack_o pulses with correct data each.
